// File: rtl/cm3_matrix_pkg.sv
// Shared AHB encodings and widths for the cm3_matrix bus matrix.
package cm3_matrix_pkg;

  // Width of the address-phase user sideband.
  localparam int AUSER_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

endpackage

// File: rtl/cm3_matrix_input_hold.sv
// Address-phase holding stage for one master-facing input port of cm3_matrix.
// Registers the master's address phase when the decoder cannot yet route it,
// stalls the master, replays the held transfer until the output stage accepts
// it, then tracks the data phase and returns the decoder's response.
// Optional feature macro: CM3_MATRIX_AUSER_EN (adds HAUSERS and its holding flops).
module cm3_matrix_input_hold
  import cm3_matrix_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELS,
  input  logic [AW-1:0]      HADDRS,
  input  logic [1:0]         HTRANSS,
  input  logic               HWRITES,
  input  logic [2:0]         HSIZES,
  input  logic [2:0]         HBURSTS,
  input  logic [3:0]         HPROTS,
  input  logic               HMASTLOCKS,
`ifdef CM3_MATRIX_AUSER_EN
  input  logic [AUSER_W-1:0] HAUSERS,
`endif
  input  logic               HREADYS,
  input  logic               active_dec,
  input  logic               readyout_dec,
  input  logic [1:0]         resp_dec,
  output logic               sel_op,
  output logic [AW-1:0]      addr_op,
  output logic [1:0]         trans_op,
  output logic               write_op,
  output logic [2:0]         size_op,
  output logic [2:0]         burst_op,
  output logic [3:0]         prot_op,
  output logic               mastlock_op,
  output logic [AUSER_W-1:0] auser_op,
  output logic               held_tran_op,
  output logic               HREADYOUTS,
  output logic [1:0]         HRESPS
);

  logic          pend_reg, pend_next;
  logic          dphase_reg, dphase_next;
  logic [AW-1:0] addr_reg;
  logic [1:0]    trans_reg;
  logic          write_reg;
  logic [2:0]    size_reg;
  logic [2:0]    burst_reg;
  logic [3:0]    prot_reg;
  logic          mastlock_reg;

  logic       load;
  logic       accept;
  logic       cancel;
  logic [1:0] trans_mux;

  assign load   = HSELS & HREADYS;
  assign accept = active_dec & readyout_dec;
  // First ERROR cycle while holding: the transfer is abandoned, not replayed.
  assign cancel = pend_reg & (resp_dec == HRESP_ERROR) & ~readyout_dec;

  // Capture the complete address phase on every load so a stall can replay it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg     <= '0;
      trans_reg    <= '0;
      write_reg    <= 1'b0;
      size_reg     <= '0;
      burst_reg    <= '0;
      prot_reg     <= '0;
      mastlock_reg <= 1'b0;
    end else if (load) begin
      addr_reg     <= HADDRS;
      trans_reg    <= HTRANSS;
      write_reg    <= HWRITES;
      size_reg     <= HSIZES;
      burst_reg    <= HBURSTS;
      prot_reg     <= HPROTS;
      mastlock_reg <= HMASTLOCKS;
    end
  end

`ifdef CM3_MATRIX_AUSER_EN
  logic [AUSER_W-1:0] auser_reg;

  // User sideband travels with the rest of the held address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      auser_reg <= '0;
    end else if (load) begin
      auser_reg <= HAUSERS;
    end
  end

  assign auser_op = pend_reg ? auser_reg : HAUSERS;
`else
  assign auser_op = '0;
`endif

  // Next-state for the hold flag and the data-phase tracker.
  always_comb begin
    pend_next   = pend_reg;
    dphase_next = dphase_reg;
    // A NONSEQ/SEQ load the decoder cannot take this cycle must be held.
    if (load && HTRANSS[1] && !accept) begin
      pend_next = 1'b1;
    end else if (accept || cancel) begin
      pend_next = 1'b0;
    end
    // A cancelled hold still owes the master the second cycle of the ERROR
    // response, so it is tracked as a data phase just like an accepted one.
    if ((accept && sel_op && trans_op[1]) || cancel) begin
      dphase_next = 1'b1;
    end else if (readyout_dec) begin
      dphase_next = 1'b0;
    end
  end

  // Hold and data-phase state flops.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_reg   <= 1'b0;
      dphase_reg <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      dphase_reg <= dphase_next;
    end
  end

  // Held values replace the live bus while pending. Select and transfer type
  // are also forced inactive during reset so no stale request leaks out.
  assign trans_mux    = pend_reg ? trans_reg : HTRANSS;
  assign trans_op     = (HRESETn && !cancel) ? trans_mux : HTRANS_IDLE;
  assign sel_op       = HRESETn & (pend_reg | HSELS);
  assign addr_op      = pend_reg ? addr_reg     : HADDRS;
  assign write_op     = pend_reg ? write_reg    : HWRITES;
  assign size_op      = pend_reg ? size_reg     : HSIZES;
  assign burst_op     = pend_reg ? burst_reg    : HBURSTS;
  assign prot_op      = pend_reg ? prot_reg     : HPROTS;
  assign mastlock_op  = pend_reg ? mastlock_reg : HMASTLOCKS;
  assign held_tran_op = pend_reg;

  // Master-side response: stall while holding, otherwise follow the decoder
  // only when this port owns a data phase.
  assign HREADYOUTS = pend_reg ? 1'b0 : (dphase_reg ? readyout_dec : 1'b1);
  assign HRESPS     = (cancel || (dphase_reg && !pend_reg)) ? resp_dec : HRESP_OKAY;

endmodule

// File: tb/tb_cm3_matrix_input_hold.sv
// Directed bench for cm3_matrix_input_hold with a scoreboard of address phases
// expected at the decoder, popped whenever the output stage accepts one.
module tb_cm3_matrix_input_hold;
  import cm3_matrix_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic [31:0] auser_drv;
  logic        HREADYS;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        sel_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic        write_op;
  logic [2:0]  size_op;
  logic [2:0]  burst_op;
  logic [3:0]  prot_op;
  logic        mastlock_op;
  logic [31:0] auser_op;
  logic        held_tran_op;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

`ifdef CM3_MATRIX_AUSER_EN
  localparam logic [31:0] EXP_HELD_AUSER = 32'hA5A5_0001;
`else
  localparam logic [31:0] EXP_HELD_AUSER = 32'h0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        held;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int failures = 0;

  // The layer HREADY is this port's own HREADYOUT, as in a single-master layer.
  assign HREADYS = HREADYOUTS;

  always #5 HCLK = ~HCLK;

  cm3_matrix_input_hold #(.AW(32)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HPROTS      (HPROTS),
    .HMASTLOCKS  (HMASTLOCKS),
`ifdef CM3_MATRIX_AUSER_EN
    .HAUSERS     (auser_drv),
`endif
    .HREADYS     (HREADYS),
    .active_dec  (active_dec),
    .readyout_dec(readyout_dec),
    .resp_dec    (resp_dec),
    .sel_op      (sel_op),
    .addr_op     (addr_op),
    .trans_op    (trans_op),
    .write_op    (write_op),
    .size_op     (size_op),
    .burst_op    (burst_op),
    .prot_op     (prot_op),
    .mastlock_op (mastlock_op),
    .auser_op    (auser_op),
    .held_tran_op(held_tran_op),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic master(input logic sel, input logic [31:0] addr, input logic [1:0] trans);
    HSELS   = sel;
    HADDRS  = addr;
    HTRANSS = trans;
  endtask

  task automatic dec(input logic act, input logic rdy, input logic [1:0] rsp);
    active_dec   = act;
    readyout_dec = rdy;
    resp_dec     = rsp;
    #1;
  endtask

  // Pop and compare whenever the output stage takes a transfer, then advance.
  task automatic cyc();
    sb_item_t it;
    if (HRESETn && sel_op && trans_op[1] && active_dec && readyout_dec) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        failures++;
        $error("FAIL sb_underflow observed_addr=%0h expected=queued_item", addr_op);
      end
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("acc_addr", 64'(addr_op), 64'(it.addr));
        chk("acc_trans", 64'(trans_op), 64'(it.trans));
        chk("acc_held", 64'(held_tran_op), 64'(it.held));
        $display("accept addr=%08h trans=%0d held=%0d", addr_op, trans_op, held_tran_op);
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    auser_drv = 32'h0;
    master(1'b1, 32'h0BAD_0000, HTRANS_NONSEQ);
    dec(1'b0, 1'b1, HRESP_OKAY);
    repeat (2) @(posedge HCLK);
    #1;
    // Reset state, with a live request on the bus that must not leak out.
    chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
    chk("rst_hresp", 64'(HRESPS), 64'd0);
    chk("rst_sel", 64'(sel_op), 64'd0);
    chk("rst_trans", 64'(trans_op), 64'd0);
    chk("rst_held", 64'(held_tran_op), 64'd0);
    HRESETn = 1'b1;
    master(1'b0, 32'h0, HTRANS_IDLE);
    dec(1'b0, 1'b1, HRESP_OKAY);
    cyc();

    // Pass-through: accepted in the load cycle.
    HWRITES = 1'b1;
    master(1'b1, 32'h0001_0040, HTRANS_NONSEQ);
    sb.push_back('{32'h0001_0040, HTRANS_NONSEQ, 1'b0});
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("pt_addr", 64'(addr_op), 64'h0001_0040);
    chk("pt_held", 64'(held_tran_op), 64'd0);
    chk("pt_hready", 64'(HREADYOUTS), 64'd1);
    chk("pt_sel", 64'(sel_op), 64'd1);
    cyc();
    master(1'b0, 32'h0, HTRANS_IDLE);
    dec(1'b1, 1'b0, HRESP_OKAY);
    chk("pt_dphase_wait", 64'(HREADYOUTS), 64'd0);
    cyc();
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("pt_dphase_done", 64'(HREADYOUTS), 64'd1);
    chk("pt_hresp", 64'(HRESPS), 64'd0);
    cyc();

    // Held transfer: decoder busy for the load cycle plus three more.
    HWRITES = 1'b0;
    auser_drv = 32'hA5A5_0001;
    master(1'b1, 32'h2000_0000, HTRANS_NONSEQ);
    sb.push_back('{32'h2000_0000, HTRANS_NONSEQ, 1'b1});
    dec(1'b0, 1'b1, HRESP_OKAY);
    chk("hold_load_held", 64'(held_tran_op), 64'd0);
    chk("hold_load_hready", 64'(HREADYOUTS), 64'd1);
    cyc();
    master(1'b1, 32'hDEAD_BEE0, HTRANS_SEQ);
    auser_drv = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      dec(1'b0, 1'b1, HRESP_OKAY);
      chk("hold_held", 64'(held_tran_op), 64'd1);
      chk("hold_addr", 64'(addr_op), 64'h2000_0000);
      chk("hold_trans", 64'(trans_op), 64'(HTRANS_NONSEQ));
      chk("hold_sel", 64'(sel_op), 64'd1);
      chk("hold_hready", 64'(HREADYOUTS), 64'd0);
      chk("hold_auser", 64'(auser_op), 64'(EXP_HELD_AUSER));
      cyc();
    end
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("hold_acc_hready", 64'(HREADYOUTS), 64'd0);
    cyc();
    master(1'b1, 32'h0, HTRANS_IDLE);
    auser_drv = 32'h0;
    dec(1'b1, 1'b0, HRESP_OKAY);
    chk("hold_dphase_wait", 64'(HREADYOUTS), 64'd0);
    chk("hold_dphase_held", 64'(held_tran_op), 64'd0);
    cyc();
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("hold_dphase_done", 64'(HREADYOUTS), 64'd1);
    cyc();

    // Cancel: ERROR while holding drops the transfer with a two-cycle response.
    master(1'b1, 32'h3000_0100, HTRANS_NONSEQ);
    dec(1'b0, 1'b1, HRESP_OKAY);
    cyc();
    master(1'b1, 32'h3000_0100, HTRANS_NONSEQ);
    dec(1'b0, 1'b0, HRESP_ERROR);
    chk("cancel_trans", 64'(trans_op), 64'd0);
    chk("cancel_hresp1", 64'(HRESPS), 64'd1);
    chk("cancel_hready1", 64'(HREADYOUTS), 64'd0);
    cyc();
    master(1'b0, 32'h0, HTRANS_IDLE);
    dec(1'b0, 1'b1, HRESP_ERROR);
    chk("cancel_hresp2", 64'(HRESPS), 64'd1);
    chk("cancel_hready2", 64'(HREADYOUTS), 64'd1);
    chk("cancel_held", 64'(held_tran_op), 64'd0);
    cyc();
    dec(1'b0, 1'b1, HRESP_OKAY);
    chk("cancel_no_replay_sel", 64'(sel_op), 64'd0);
    chk("cancel_hresp_ok", 64'(HRESPS), 64'd0);
    cyc();

    // Burst with decoder ready toggling 1,0,1: HREADYOUT mirrors, no hold.
    master(1'b1, 32'h4000_0000, HTRANS_NONSEQ);
    sb.push_back('{32'h4000_0000, HTRANS_NONSEQ, 1'b0});
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("burst0_hready", 64'(HREADYOUTS), 64'd1);
    cyc();
    master(1'b1, 32'h4000_0004, HTRANS_SEQ);
    sb.push_back('{32'h4000_0004, HTRANS_SEQ, 1'b0});
    dec(1'b1, 1'b0, HRESP_OKAY);
    chk("burst1_hready", 64'(HREADYOUTS), 64'd0);
    chk("burst1_held", 64'(held_tran_op), 64'd0);
    cyc();
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("burst2_hready", 64'(HREADYOUTS), 64'd1);
    chk("burst2_held", 64'(held_tran_op), 64'd0);
    cyc();
    master(1'b1, 32'h4000_0008, HTRANS_SEQ);
    sb.push_back('{32'h4000_0008, HTRANS_SEQ, 1'b0});
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("burst3_hready", 64'(HREADYOUTS), 64'd1);
    cyc();
    master(1'b0, 32'h0, HTRANS_IDLE);
    dec(1'b0, 1'b1, HRESP_OKAY);
    chk("burst_end_hready", 64'(HREADYOUTS), 64'd1);
    cyc();

    // Reset while holding: outputs drop to reset values at once, no replay.
    master(1'b1, 32'h5000_0000, HTRANS_NONSEQ);
    dec(1'b0, 1'b1, HRESP_OKAY);
    cyc();
    chk("rsthold_held_pre", 64'(held_tran_op), 64'd1);
    HRESETn = 1'b0;
    #1;
    chk("rsthold_hready", 64'(HREADYOUTS), 64'd1);
    chk("rsthold_sel", 64'(sel_op), 64'd0);
    chk("rsthold_trans", 64'(trans_op), 64'd0);
    chk("rsthold_held", 64'(held_tran_op), 64'd0);
    cyc();
    master(1'b0, 32'h0, HTRANS_IDLE);
    cyc();
    HRESETn = 1'b1;
    dec(1'b1, 1'b1, HRESP_OKAY);
    chk("rsthold_after_sel", 64'(sel_op), 64'd0);
    chk("rsthold_after_held", 64'(held_tran_op), 64'd0);
    cyc();
    chk("rsthold_after_hready", 64'(HREADYOUTS), 64'd1);
    chk("rsthold_after_trans", 64'(trans_op), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
